// File: rtl/iter_shift_unit.sv
// Multi-cycle logical-left shifter: repeatedly applies a 4-bit or 1-bit shift
// step to an accumulator until the captured shift amount is exhausted.
module iter_shift_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_data,
  input  logic [CNT_W-1:0] shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] step4, step1;

  assign step4 = {acc_q[WIDTH-5:0], 4'b0000};
  assign step1 = {acc_q[WIDTH-2:0], 1'b0};

  // busy/done/result are computed from the next state so they can be registered
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    done_d   = 1'b0;
    busy_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = op_data;
          cnt_d = shamt;
          if (shamt == '0) begin
            state_d  = DONE;
            done_d   = 1'b1;
            result_d = op_data;
          end else begin
            state_d = SHIFT;
            busy_d  = 1'b1;
          end
        end
      end
      SHIFT: begin
        if (cnt_q >= CNT_W'(4)) begin
          acc_d = step4;
          cnt_d = cnt_q - CNT_W'(4);
        end else begin
          acc_d = step1;
          cnt_d = cnt_q - CNT_W'(1);
        end
        if (cnt_d == '0) begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = acc_d;
        end else begin
          busy_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
